// File: rtl/hdmi_i2c_init_seq_pkg.sv
// Shared types and constants for the HDMI transmitter I2C init sequencer.
package hdmi_init_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWRUP,
      ST_FETCH,
      ST_SEND_REG,
      ST_SEND_VAL,
      ST_WAIT_STOP,
      ST_DELAY,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } state_t;

   // A table entry is {register, value}; register DELAY_CMD means "wait value ms".
   localparam int unsigned    ENTRY_W   = 16;
   localparam logic [7:0]     DELAY_CMD = 8'hFF;
   // Returned past the end of the table: a zero-length delay, harmless if reached.
   localparam logic [ENTRY_W-1:0] ENTRY_PAD = 16'hFF00;

endpackage

// File: rtl/hdmi_i2c_init_seq_if.sv
// Byte-level handshake between the init sequencer and the HDMI I2C PHY wrapper.
interface hdmi_i2c_init_seq_if;

   logic       m_en;   // transaction request, held for the whole write
   logic       m_wr;   // write direction, always 1 here
   logic       last;   // final byte of the transaction is presented
   logic [6:0] addr;   // 7-bit device address
   logic [7:0] data;   // current byte
   logic       ack;    // PHY accepted and ACKed the current byte (1-cycle pulse)
   logic       stop;   // PHY finished the STOP condition (1-cycle pulse)

   modport master (output m_en, m_wr, last, addr, data, input ack, stop);
   modport slave  (input m_en, m_wr, last, addr, data, output ack, stop);

endinterface

// File: rtl/hdmi_i2c_init_seq_rom.sv
// Constant ADV7511 power-up register table, one {register, value} pair per index.
module hdmi_init_rom
   import hdmi_init_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 32
) (
   input  logic [7:0]         index,
   output logic [ENTRY_W-1:0] entry
);

   // Combinational table lookup; indices past NUM_ENTRIES read as a null delay.
   always_comb begin
      entry = ENTRY_PAD;
      if (32'(index) < NUM_ENTRIES) begin
         case (index)
            8'd0:    entry = 16'h4110;  // power up the transmitter
            8'd1:    entry = 16'h9803;  // fixed register
            8'd2:    entry = 16'hFF02;  // let the supplies settle, 2 ms
            8'd3:    entry = 16'h9AE0;
            8'd4:    entry = 16'h9C30;
            8'd5:    entry = 16'h9D61;
            8'd6:    entry = 16'hA2A4;
            8'd7:    entry = 16'hA3A4;
            8'd8:    entry = 16'hE0D0;
            8'd9:    entry = 16'hF900;
            8'd10:   entry = 16'h1500;  // 24-bit RGB 4:4:4 input
            8'd11:   entry = 16'h1630;
            8'd12:   entry = 16'h1702;
            8'd13:   entry = 16'h1846;  // CSC off
            8'd14:   entry = 16'hAF06;  // HDMI mode
            8'd15:   entry = 16'h4080;
            8'd16:   entry = 16'h4808;
            8'd17:   entry = 16'h49A8;
            8'd18:   entry = 16'h4C00;
            8'd19:   entry = 16'h5500;
            8'd20:   entry = 16'h5608;
            8'd21:   entry = 16'h9620;
            8'd22:   entry = 16'hD03C;
            8'd23:   entry = 16'hBA60;
            8'd24:   entry = 16'hD6C0;
            8'd25:   entry = 16'h0A01;
            8'd26:   entry = 16'h0B0E;
            8'd27:   entry = 16'h0C00;
            8'd28:   entry = 16'hD500;
            8'd29:   entry = 16'hE460;
            8'd30:   entry = 16'hFA7D;
            8'd31:   entry = 16'hFF00;
            default: entry = ENTRY_PAD;
         endcase
      end
   end

endmodule

// File: rtl/hdmi_i2c_init_seq.sv
// Walks the init table and turns each {register, value} entry into one
// S-ADDR-W-K, REG-K, VAL-K, P write through the PHY; 8'hFF entries are ms delays.
module hdmi_i2c_init_seq
   import hdmi_init_pkg::*;
#(
   parameter logic [6:0]  DEVICE_ADDRESS = 7'h39,
   parameter int unsigned SYSCLK_FREQ    = 100,
   parameter int unsigned NUM_ENTRIES    = 32,
   parameter int unsigned PWRUP_DELAY_MS = 200,
   parameter int unsigned TIMEOUT_US     = 1000,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic                i_sysclk,
   input  logic                i_arstn,
   input  logic                i_start,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_error,
   output logic [7:0]          o_err_index,
   hdmi_i2c_init_seq_if.master phy
);

   localparam int unsigned MS_MAX      = SYSCLK_FREQ * 1000 - 1;
   localparam int unsigned TO_LIMIT    = TIMEOUT_US * SYSCLK_FREQ;
   localparam logic [7:0]  LAST_INDEX  = 8'(NUM_ENTRIES - 1);
   localparam logic [15:0] PWRUP_LAST  = 16'(PWRUP_DELAY_MS - 1);
   localparam state_t      RESET_STATE = AUTO_START ? ST_PWRUP : ST_IDLE;

   state_t              state_q, state_d;
   logic [7:0]          index_q, index_d;
   logic [15:0]         dly_cnt_q, dly_cnt_d;
   logic [7:0]          dly_target_q, dly_target_d;
   logic [31:0]         to_cnt_q, to_cnt_d;
   logic [31:0]         ms_cnt_q;
   logic                ms_run, ms_tick;
   logic                start_q, start_rise;
   logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [7:0]          err_index_q, err_index_d;
   logic                m_en_q, m_en_d, last_q, last_d;
   logic [7:0]          data_q, data_d;
   logic [ENTRY_W-1:0]  entry;
   logic [7:0]          ent_reg, ent_val;

   hdmi_init_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (
      .index (index_q),
      .entry (entry)
   );

   assign ent_reg    = entry[15:8];
   assign ent_val    = entry[7:0];
   assign start_rise = i_start & ~start_q;
   assign ms_run     = (state_q == ST_PWRUP) || (state_q == ST_DELAY);
   assign ms_tick    = ms_run && (ms_cnt_q == MS_MAX);

   // Millisecond prescaler, held at zero outside the waiting states.
   always_ff @(posedge i_sysclk or negedge i_arstn) begin
      if (!i_arstn)
         ms_cnt_q <= '0;
      else if (!ms_run || ms_tick)
         ms_cnt_q <= '0;
      else
         ms_cnt_q <= ms_cnt_q + 32'd1;
   end

   // Next state, counters and registered outputs; outputs decode state_d so
   // they change on the same edge as the state they belong to.
   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      dly_cnt_d    = dly_cnt_q;
      dly_target_d = dly_target_q;
      to_cnt_d     = '0;
      done_d       = done_q;
      error_d      = error_q;
      err_index_d  = err_index_q;

      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               done_d  = 1'b0;
               error_d = 1'b0;
               index_d = '0;
               state_d = ST_FETCH;
            end
         end
         ST_PWRUP: begin
            if (PWRUP_DELAY_MS == 0) begin
               state_d = ST_FETCH;
            end else if (ms_tick) begin
               if (dly_cnt_q == PWRUP_LAST) begin
                  dly_cnt_d = '0;
                  state_d   = ST_FETCH;
               end else begin
                  dly_cnt_d = dly_cnt_q + 16'd1;
               end
            end
         end
         ST_FETCH: begin
            dly_cnt_d = '0;
            if (ent_reg == DELAY_CMD) begin
               dly_target_d = ent_val;
               state_d      = (ent_val == 8'd0) ? ST_NEXT : ST_DELAY;
            end else begin
               state_d = ST_SEND_REG;
            end
         end
         ST_SEND_REG: begin
            if (phy.ack)
               state_d = ST_SEND_VAL;
            else if (to_cnt_q == TO_LIMIT - 1)
               state_d = ST_ERROR;
            else
               to_cnt_d = to_cnt_q + 32'd1;
         end
         ST_SEND_VAL: begin
            // ACK of the last byte and STOP completion may coincide.
            if (phy.ack && phy.stop)
               state_d = ST_NEXT;
            else if (phy.ack)
               state_d = ST_WAIT_STOP;
            else if (to_cnt_q == TO_LIMIT - 1)
               state_d = ST_ERROR;
            else
               to_cnt_d = to_cnt_q + 32'd1;
         end
         ST_WAIT_STOP: begin
            if (phy.stop)
               state_d = ST_NEXT;
            else if (phy.ack)
               to_cnt_d = '0;
            else if (to_cnt_q == TO_LIMIT - 1)
               state_d = ST_ERROR;
            else
               to_cnt_d = to_cnt_q + 32'd1;
         end
         ST_DELAY: begin
            if (ms_tick) begin
               if (dly_cnt_q == 16'(dly_target_q) - 16'd1) begin
                  dly_cnt_d = '0;
                  state_d   = ST_NEXT;
               end else begin
                  dly_cnt_d = dly_cnt_q + 16'd1;
               end
            end
         end
         ST_NEXT: begin
            if (index_q == LAST_INDEX) begin
               state_d = ST_DONE;
            end else begin
               index_d = index_q + 8'd1;
               state_d = ST_FETCH;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (state_d == ST_DONE)
         done_d = 1'b1;
      if (state_d == ST_ERROR && state_q != ST_ERROR) begin
         error_d     = 1'b1;
         err_index_d = index_q;
      end

      busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
      m_en_d = state_d inside {ST_SEND_REG, ST_SEND_VAL, ST_WAIT_STOP};
      last_d = state_d inside {ST_SEND_VAL, ST_WAIT_STOP};
      case (state_d)
         ST_SEND_REG:               data_d = ent_reg;
         ST_SEND_VAL, ST_WAIT_STOP: data_d = ent_val;
         default:                   data_d = '0;
      endcase
   end

   // State and output registers; reset drops the PHY request immediately.
   always_ff @(posedge i_sysclk or negedge i_arstn) begin
      if (!i_arstn) begin
         state_q      <= RESET_STATE;
         index_q      <= '0;
         dly_cnt_q    <= '0;
         dly_target_q <= '0;
         to_cnt_q     <= '0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_index_q  <= '0;
         m_en_q       <= 1'b0;
         last_q       <= 1'b0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         dly_cnt_q    <= dly_cnt_d;
         dly_target_q <= dly_target_d;
         to_cnt_q     <= to_cnt_d;
         start_q      <= i_start;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_index_q  <= err_index_d;
         m_en_q       <= m_en_d;
         last_q       <= last_d;
         data_q       <= data_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_error     = error_q;
   assign o_err_index = err_index_q;
   assign phy.m_en    = m_en_q;
   assign phy.m_wr    = 1'b1;
   assign phy.last    = last_q;
   assign phy.addr    = DEVICE_ADDRESS;
   assign phy.data    = data_q;

endmodule

// File: tb/tb_hdmi_i2c_init_seq.sv
// Scoreboarded bench for the HDMI init sequencer with a simple PHY responder.
`timescale 1ns/1ps
module tb_hdmi_i2c_init_seq;

   localparam int unsigned N_ENT    = 4;
   localparam int unsigned TO_US    = 30;
   localparam int unsigned ACK_LAT  = 10;
   localparam int unsigned STOP_LAT = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, error;
   logic [7:0] err_index;

   hdmi_i2c_init_seq_if phy_if ();

   hdmi_i2c_init_seq #(
      .DEVICE_ADDRESS (7'h39),
      .SYSCLK_FREQ    (1),
      .NUM_ENTRIES    (N_ENT),
      .PWRUP_DELAY_MS (1),
      .TIMEOUT_US     (TO_US),
      .AUTO_START     (1'b1)
   ) dut (
      .i_sysclk    (clk),
      .i_arstn     (rst_n),
      .i_start     (start),
      .o_busy      (busy),
      .o_done      (done),
      .o_error     (error),
      .o_err_index (err_index),
      .phy         (phy_if.master)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected ADV7511 table head as used with four entries.
   bit [15:0] tbl [N_ENT] = '{16'h4110, 16'h9803, 16'hFF02, 16'h9AE0};

   int        n_checks = 0;
   int        n_errors = 0;
   bit [8:0]  exp_q [$];   // {last, data}

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_write(input int i);
      exp_q.push_back({1'b0, tbl[i][15:8]});
      exp_q.push_back({1'b1, tbl[i][7:0]});
   endtask

   task automatic push_run();
      for (int i = 0; i < N_ENT; i++)
         if (tbl[i][15:8] != 8'hFF) push_write(i);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_eidx"},  err_index, 0);
      check({tag, "_m_en"},  phy_if.m_en, 0);
      check({tag, "_m_wr"},  phy_if.m_wr, 1);
      check({tag, "_last"},  phy_if.last, 0);
      check({tag, "_addr"},  phy_if.addr, 7'h39);
      check({tag, "_data"},  phy_if.data, 0);
   endtask

   task automatic wait_m_en(input string tag, input int unsigned budget, output int unsigned waited);
      waited = 0;
      while (phy_if.m_en !== 1'b1 && waited < budget) begin
         tick();
         waited++;
      end
      check({tag, "_m_en_rise"}, phy_if.m_en, 1);
   endtask

   // Present one byte to the scoreboard, then ACK it (optionally with STOP).
   task automatic phy_byte(input string tag, input bit hold_ack, input bit with_stop);
      bit [8:0] e;
      repeat (ACK_LAT) tick();
      check({tag, "_sb_avail"}, exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, phy_if.data, e[7:0]);
         check({tag, "_last"}, phy_if.last, e[8]);
         check({tag, "_m_en"}, phy_if.m_en, 1);
         check({tag, "_addr"}, phy_if.addr, 7'h39);
      end
      if (!hold_ack) begin
         phy_if.ack  = 1'b1;
         phy_if.stop = with_stop;
         tick();
         phy_if.ack  = 1'b0;
         phy_if.stop = 1'b0;
      end
   endtask

   task automatic phy_write(input string tag, input bit same_cycle, input bit stray_ack,
                            output int unsigned stop_cyc);
      phy_byte({tag, "_reg"}, 1'b0, 1'b0);
      phy_byte({tag, "_val"}, 1'b0, same_cycle);
      if (!same_cycle) begin
         if (stray_ack) begin
            tick();
            phy_if.ack = 1'b1;
            tick();
            phy_if.ack = 1'b0;
            check({tag, "_stray_m_en"}, phy_if.m_en, 1);
            check({tag, "_stray_last"}, phy_if.last, 1);
         end
         repeat (STOP_LAT) tick();
         check({tag, "_ws_last"}, phy_if.last, 1);
         phy_if.stop = 1'b1;
         tick();
         phy_if.stop = 1'b0;
      end
      check({tag, "_end_m_en"}, phy_if.m_en, 0);
      check({tag, "_end_last"}, phy_if.last, 0);
      stop_cyc = cyc;
   endtask

   task automatic run_body(input string tag, input bit sc0, input bit poke_start);
      int unsigned s, w, gap;
      phy_write({tag, "_e0"}, sc0, 1'b0, s);
      wait_m_en({tag, "_e1"}, 10, w);
      check({tag, "_e0_to_e1_cycles"}, w, 2);
      phy_write({tag, "_e1"}, 1'b0, 1'b0, s);
      if (poke_start) begin
         repeat (5) tick();
         check({tag, "_busy_in_delay"}, busy, 1);
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      wait_m_en({tag, "_e3"}, 2200, w);
      gap = cyc - s;
      check({tag, "_delay_gap_ok"}, (gap >= 2000) && (gap <= 2020), 1);
      phy_write({tag, "_e3"}, 1'b0, !sc0, s);
      w = 0;
      while (done !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      check({tag, "_done"},  done, 1);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w, r;
      phy_if.ack  = 1'b0;
      phy_if.stop = 1'b0;

      // Power-on reset, then automatic run after the power-up wait.
      repeat (3) tick();
      check_reset("rst0");
      push_run();
      rst_n = 1'b1;
      repeat (3) tick();
      check("pwrup_busy", busy, 1);
      check("pwrup_m_en", phy_if.m_en, 0);
      wait_m_en("pwrup", 1100, w);
      check("pwrup_len_ok", (w >= 997) && (w <= 1010), 1);
      run_body("auto", 1'b0, 1'b0);

      // Manual rerun: no power-up wait; coincident ACK+STOP; start ignored while busy.
      repeat (4) tick();
      push_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rerun_done_clr", done, 0);
      check("rerun_busy", busy, 1);
      wait_m_en("rerun", 5, w);
      check("rerun_no_pwrup", w <= 2, 1);
      run_body("rerun", 1'b1, 1'b1);

      // Entry 1 never ACKed: timeout, no retry.
      repeat (4) tick();
      push_write(0);
      exp_q.push_back({1'b0, tbl[1][15:8]});
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_m_en("to_e0", 5, w);
      phy_write("to_e0", 1'b0, 1'b0, r);
      wait_m_en("to_e1", 10, w);
      r = cyc;
      phy_byte("to_e1_reg", 1'b1, 1'b0);
      w = 0;
      while (phy_if.m_en === 1'b1 && w < 60) begin
         tick();
         w++;
      end
      check("to_len", cyc - r, TO_US);
      check("to_error", error, 1);
      check("to_err_index", err_index, 1);
      check("to_m_en", phy_if.m_en, 0);
      check("to_last", phy_if.last, 0);
      check("to_done", done, 0);
      check("to_busy", busy, 0);
      repeat (20) tick();
      check("to_no_retry_m_en", phy_if.m_en, 0);
      check("to_sticky_error", error, 1);
      check("to_sb_empty", exp_q.size(), 0);

      // Reset while the value byte is on the bus.
      exp_q.push_back({1'b0, tbl[0][15:8]});
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_m_en("rst_e0", 5, w);
      phy_byte("rst_e0_reg", 1'b0, 1'b0);
      tick();
      check("rst_in_send_val_last", phy_if.last, 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_m_en", phy_if.m_en, 0);
      tick();
      check_reset("rst1");
      check("rst1_sb_empty", exp_q.size(), 0);
      push_run();
      rst_n = 1'b1;
      wait_m_en("rst1_pwrup", 1100, w);
      check("rst1_pwrup_len_ok", (w >= 997) && (w <= 1010), 1);
      run_body("after_rst", 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
